// File: rtl/servo_pwm_frame_gen_pkg.sv
// Shared constants for the servo PWM chain: frame period, pulse limits, frame-index modulus
// and failsafe threshold. The modulator imports the same pulse constants.
package servo_pwm_frame_gen_pkg;

    localparam int unsigned CLK_RATE_DEF      = 100_000_000;
    localparam int unsigned FRAME_HZ_DEF      = 50;
    localparam int unsigned MIN_PULSE_DEF     = 100_000;
    localparam int unsigned MAX_PULSE_DEF     = 200_000;
    localparam int unsigned NEUTRAL_PULSE_DEF = 150_000;

    localparam int unsigned NUM_STATES      = 24;
    localparam int unsigned FAILSAFE_FRAMES = 10;

    localparam int unsigned CNT_W   = 21;
    localparam int unsigned PULSE_W = 21;
    localparam int unsigned STATE_W = 5;
    localparam int unsigned WD_W    = 4;

    // Width and run flag applied for one whole frame
    typedef struct packed {
        logic               run;
        logic [PULSE_W-1:0] width;
    } frame_cfg_t;

    function automatic int unsigned frame_period(input int unsigned clk_rate,
                                                 input int unsigned frame_hz);
        return clk_rate / frame_hz;
    endfunction

    function automatic logic [PULSE_W-1:0] clamp_pulse(input logic [PULSE_W-1:0] p,
                                                       input logic [PULSE_W-1:0] lo,
                                                       input logic [PULSE_W-1:0] hi);
        if (p < lo) return lo;
        if (p > hi) return hi;
        return p;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter 0..PERIOD-1 with frame-start strobe, mid-frame and latch ticks.
module servo_frame_timer
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int unsigned PERIOD = 2_000_000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [CNT_W-1:0] count_nxt_c_o,
    output logic             mid_tick_c_o,
    output logic             latch_tick_c_o,
    output logic             frame_start_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        latch_tick_c_o = (count_q == CNT_W'(PERIOD - 1));
        mid_tick_c_o   = (count_q == CNT_W'(PERIOD / 2));
        count_d        = latch_tick_c_o ? '0 : count_q + CNT_W'(1);
        frame_start_d  = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign count_nxt_c_o = count_d;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/servo_pwm_frame_gen.sv
// Servo frame generator: frame index to the modulator, per-frame width latch with clamp, PWM line.
// Optional frame watchdog forcing neutral output is built when PWM_FAILSAFE_EN is defined.
module servo_pwm_frame_gen
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int unsigned CLK_RATE      = CLK_RATE_DEF,
    parameter int unsigned FRAME_HZ      = FRAME_HZ_DEF,
    parameter int unsigned MIN_PULSE     = MIN_PULSE_DEF,
    parameter int unsigned MAX_PULSE     = MAX_PULSE_DEF,
    parameter int unsigned NEUTRAL_PULSE = NEUTRAL_PULSE_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Enable,
    input  logic [PULSE_W-1:0] Pulse,
    output logic [STATE_W-1:0] State,
    output logic               PwmOut,
    output logic               FrameStart
`ifdef PWM_FAILSAFE_EN
    ,
    input  logic               Kick
`endif
);

    localparam int unsigned PERIOD = frame_period(CLK_RATE, FRAME_HZ);

    logic [CNT_W-1:0]   count_nxt;
    logic               mid_tick;
    logic               latch_tick;

    frame_cfg_t         cfg_q, cfg_d, cfg_req;
    logic [STATE_W-1:0] state_q, state_d;
    logic               pwm_q, pwm_d;

    servo_frame_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk_i          (CLK),
        .rst_n_i        (RST_N),
        .count_nxt_c_o  (count_nxt),
        .mid_tick_c_o   (mid_tick),
        .latch_tick_c_o (latch_tick),
        .frame_start_o  (FrameStart)
    );

`ifdef PWM_FAILSAFE_EN
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    logic            kick_seen_q, kick_seen_d;
`endif

    always_comb begin
        cfg_d       = cfg_q;
        state_d     = state_q;
        cfg_req.run   = Enable;
        cfg_req.width = clamp_pulse(Pulse, PULSE_W'(MIN_PULSE), PULSE_W'(MAX_PULSE));

        // Mid-frame index advance gives the modulator half a frame to settle
        if (mid_tick) begin
            state_d = (state_q == STATE_W'(NUM_STATES - 1)) ? '0 : state_q + STATE_W'(1);
        end

`ifdef PWM_FAILSAFE_EN
        wd_d        = wd_q;
        kick_seen_d = kick_seen_q | Kick;
        wd_inc      = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
        if (Kick) begin
            wd_d = '0;
        end
        if (latch_tick) begin
            kick_seen_d = 1'b0;
            if (kick_seen_q || Kick) begin
                wd_d  = '0;
                cfg_d = cfg_req;
            end else begin
                wd_d = wd_inc;
                // Lost heartbeat: hold motors at neutral until navigation kicks again
                if (wd_inc >= WD_W'(FAILSAFE_FRAMES)) begin
                    cfg_d.run   = 1'b1;
                    cfg_d.width = PULSE_W'(NEUTRAL_PULSE);
                end else begin
                    cfg_d = cfg_req;
                end
            end
        end
`else
        if (latch_tick) begin
            cfg_d = cfg_req;
        end
`endif

        // Evaluated against next-cycle counter/config so the high time starts on counter 0
        pwm_d = cfg_d.run && (count_nxt < cfg_d.width);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cfg_q.run   <= 1'b0;
            cfg_q.width <= PULSE_W'(NEUTRAL_PULSE);
            state_q     <= '0;
            pwm_q       <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            state_q     <= state_d;
            pwm_q       <= pwm_d;
        end
    end

`ifdef PWM_FAILSAFE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_q        <= '0;
            kick_seen_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            kick_seen_q <= kick_seen_d;
        end
    end
`endif

    assign State  = state_q;
    assign PwmOut = pwm_q;

endmodule

// File: tb/tb_servo_pwm_frame_gen.sv
// Bench for servo_pwm_frame_gen with a scaled frame (400 cycles); PWM_FAILSAFE_EN selects the watchdog checks.
module tb_servo_pwm_frame_gen;

    localparam int P      = 400;
    localparam int T_MIN  = 100;
    localparam int T_MAX  = 200;
    localparam int T_NEU  = 150;
    localparam int NFR    = 64;

    logic        CLK;
    logic        RST_N;
    logic        Enable;
    logic [20:0] Pulse;
    logic [4:0]  State;
    logic        PwmOut;
    logic        FrameStart;
    logic        Kick;

    servo_pwm_frame_gen #(
        .CLK_RATE      (20_000),
        .FRAME_HZ      (50),
        .MIN_PULSE     (T_MIN),
        .MAX_PULSE     (T_MAX),
        .NEUTRAL_PULSE (T_NEU)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Enable     (Enable),
        .Pulse      (Pulse),
        .State      (State),
        .PwmOut     (PwmOut),
        .FrameStart (FrameStart)
`ifdef PWM_FAILSAFE_EN
        ,
        .Kick       (Kick)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: k = rising edges since reset release; per-frame latched run/width
    int k;
    bit exp_run [NFR];
    int exp_w   [NFR];
    int wd_m;
    bit kick_m;
    int d_hi, e_hi, bad, bad_ph, last_hi;

    typedef struct {
        logic        en;
        logic [20:0] pulse;
        int          exp_hi;
    } vec_t;
    vec_t tbl [9];

    function automatic int clampm(input int x);
        if (x < T_MIN) return T_MIN;
        if (x > T_MAX) return T_MAX;
        return x;
    endfunction

    function automatic int exp_state(input int kk);
        if (kk < P / 2 + 1) return 0;
        return ((kk - P / 2 - 1) / P + 1) % 24;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic latch_model(input int fn, input logic en, input logic [20:0] pw);
        bit r;
        int w;
        r = en;
        w = clampm(int'(pw));
`ifdef PWM_FAILSAFE_EN
        if (kick_m) begin
            wd_m = 0;
        end else begin
            wd_m = (wd_m < 15) ? wd_m + 1 : 15;
            if (wd_m >= 10) begin
                r = 1'b1;
                w = T_NEU;
            end
        end
        kick_m = 1'b0;
`endif
        if (fn < NFR) begin
            exp_run[fn] = r;
            exp_w[fn]   = w;
        end
    endtask

    task automatic model_reset();
        k = 0; wd_m = 0; kick_m = 1'b0;
        d_hi = 0; e_hi = 0; bad = 0; bad_ph = 0;
        exp_run[0] = 1'b0;
        exp_w[0]   = T_NEU;
    endtask

    // One cycle: compare outputs at the falling edge, then drive inputs for the next rising edge
    task automatic tick(input logic en, input logic [20:0] pw, input logic kk);
        int  ph, f, e_st;
        bit  e_pwm, e_fs;
        @(negedge CLK);
        ph    = k % P;
        f     = k / P;
        e_pwm = (f >= 1) && (f < NFR) && exp_run[f] && (ph < exp_w[f]);
        e_fs  = (k > 0) && (ph == 0);
        e_st  = exp_state(k);
        d_hi += int'(PwmOut === 1'b1);
        e_hi += int'(e_pwm);
        if (PwmOut !== e_pwm || FrameStart !== e_fs || State !== 5'(e_st)) begin
            if (bad == 0) bad_ph = ph;
            bad++;
        end
        if (ph == P - 1) begin
            checks++;
            if (bad != 0 || d_hi != e_hi) begin
                errors++;
                $display("FAIL frame%0d: high=%0d expected %0d, %0d bad cycles first at phase %0d",
                         f, d_hi, e_hi, bad, bad_ph);
            end
            last_hi = d_hi;
            d_hi = 0; e_hi = 0; bad = 0;
        end
        Enable = en;
        Pulse  = pw;
        Kick   = kk;
        if (kk) kick_m = 1'b1;
        if (ph == P - 1) latch_model(f + 1, en, pw);
        k++;
    endtask

    task automatic run_frame(input logic en0, input logic [20:0] pw0,
                             input logic en1, input logic [20:0] pw1,
                             input int chg, input int kph);
        for (int ph = 0; ph < P; ph++) begin
            if (ph < chg) tick(en0, pw0, 1'(ph == kph));
            else          tick(en1, pw1, 1'(ph == kph));
        end
    endtask

    initial begin
        logic [20:0] rp;
        RST_N  = 1'b0;
        Enable = 1'b0;
        Pulse  = 21'd100;
        Kick   = 1'b0;
        last_hi = 0;
        model_reset();

        #1;
        check("reset_pwm",   int'(PwmOut),     0);
        check("reset_fs",    int'(FrameStart), 0);
        check("reset_state", int'(State),      0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        tbl[0] = '{1'b0, 21'd100,     0};
        tbl[1] = '{1'b1, 21'd100,     100};
        tbl[2] = '{1'b1, 21'd250,     200};
        tbl[3] = '{1'b1, 21'd0,       100};
        tbl[4] = '{1'b1, 21'd150,     150};
        tbl[5] = '{1'b0, 21'd200,     0};
        tbl[6] = '{1'b1, 21'h1FFFFF,  200};
        tbl[7] = '{1'b1, 21'd199,     199};
        tbl[8] = '{1'b1, 21'd101,     101};

        // Frame i carries table entry i; its latched width shows up as frame i+1 high time
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].en, tbl[i].pulse, tbl[i].en, tbl[i].pulse, P, 0);
            if (i == 0) check("first_frame_hi", last_hi, 0);
            else        check($sformatf("tbl%0d_width", i - 1), last_hi, tbl[i - 1].exp_hi);
        end
        run_frame(1'b1, 21'd100, 1'b1, 21'd100, P, 3);
        check("tbl8_width", last_hi, tbl[8].exp_hi);

        // Random frames with mid-frame changes; frame 11 changes exactly on the latch cycle
        for (int i = 0; i < 16; i++) begin
            logic       e0, e1;
            logic [20:0] p0, p1;
            int          chg, kph;
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 3) != 0);
            p0 = 21'($urandom_range(0, 300));
            case ($urandom_range(0, 3))
                0:       p1 = 21'($urandom_range(0, 99));
                1:       p1 = 21'($urandom_range(100, 200));
                2:       p1 = 21'($urandom_range(201, 1000));
                default: begin rp = 21'($urandom); p1 = rp; end
            endcase
            chg = (i == 1) ? P - 1 : $urandom_range(1, P);
            kph = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, P - 1);
            run_frame(e0, p0, e1, p1, chg, kph);
        end

        // Reset mid-pulse: output must drop without waiting for a clock
        run_frame(1'b1, 21'd100, 1'b1, 21'd100, P, 0);
        for (int i = 0; i < 50; i++) tick(1'b1, 21'd100, 1'b0);
        @(posedge CLK);
        #2;
        check("pwm_before_reset", int'(PwmOut), 1);
        RST_N = 1'b0;
        #1;
        check("async_reset_pwm",   int'(PwmOut),     0);
        check("async_reset_state", int'(State),      0);
        check("async_reset_fs",    int'(FrameStart), 0);
        Enable = 1'b1;
        Pulse  = 21'd200;
        Kick   = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Heartbeat loss: frames 1..9 at requested width, neutral from frame 10 when watchdog built
        for (int f = 0; f < 11; f++) begin
            run_frame(1'b1, 21'd200, 1'b1, 21'd200, P, -1);
            if (f == 0) check("post_reset_disabled", last_hi, 0);
            if (f == 9) check("frame9_width", last_hi, 200);
        end
`ifdef PWM_FAILSAFE_EN
        check("failsafe_frame10", last_hi, T_NEU);
`else
        check("no_failsafe_frame10", last_hi, 200);
`endif
        run_frame(1'b1, 21'd200, 1'b1, 21'd200, P, 100);
`ifdef PWM_FAILSAFE_EN
        check("kick_frame11", last_hi, T_NEU);
`else
        check("kick_frame11", last_hi, 200);
`endif
        run_frame(1'b1, 21'd200, 1'b1, 21'd200, P, 0);
        check("after_kick_frame12", last_hi, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
